encoder_4x2_reg: RTL and testbench

//   Registered priority encoder: the inverse of the 2-to-4 line decoder.
//   - Accepts an N-bit request word (one-hot expected) over a valid/ready handshake.
//   - Returns the binary index of the highest set bit through a one-deep output register,

---
 rtl/encoder_4x2_reg.sv | 125 ++++++++++++
 tb/tb_encoder_4x2_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_4x2_reg.sv
// encoder_4x2_reg
//   Registered priority encoder: the inverse of a 2-to-4 line decoder.
//   A request word (normally one-hot) is taken over a valid/ready handshake.
//   The binary index of its highest set bit, plus zero/multi-hot flags, is
//   returned through a one-deep output register. A saturating counter tracks
//   how many malformed (zero or multi-hot) words were accepted.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request word present on in_y
//   in_ready   out  1      block can accept in_y this cycle
//   in_y       in   N      request word, bit i = decoded line y[i]
//   out_valid  out  1      out_* hold a result
//   out_ready  in   1      consumer takes the result this cycle
//   out_a      out  W      index of highest set bit of the accepted word
//   out_zero   out  1      accepted word was all zeros
//   out_multi  out  1      accepted word had more than one bit set
//   err_cnt    out  ERR_W  saturating count of malformed accepted words
module encoder_4x2_reg #(
  parameter int N     = 4,
  parameter int W     = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_a,
  output logic             out_zero,
  output logic             out_multi,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [N-1:0] Y_ONE = N'(1);

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic             zero_q, zero_d;
  logic             multi_q, multi_d;
  logic [ERR_W-1:0] err_q, err_d;

  logic accept;
  logic release_w;
  logic word_zero;
  logic word_multi;

  // Later (higher) set bits overwrite earlier ones, giving MSB priority.
  function automatic logic [W-1:0] prio_idx(input logic [N-1:0] y);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (y[i]) idx = W'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic is_multi_hot(input logic [N-1:0] y);
    return (y & (y - Y_ONE)) != '0;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == '1) ? c : c + ERR_W'(1);
  endfunction

  // The only combinational input-to-output path.
  assign in_ready  = (state_q == EMPTY) || out_ready;
  assign accept    = in_valid && in_ready;
  assign release_w = (state_q == FULL) && out_ready;

  assign word_zero  = (in_y == '0);
  assign word_multi = is_multi_hot(in_y);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    zero_d  = zero_q;
    multi_d = multi_q;
    err_d   = err_q;
    if (accept) begin
      // Also covers simultaneous release: the new word replaces the old.
      state_d = FULL;
      a_d     = prio_idx(in_y);
      zero_d  = word_zero;
      multi_d = word_multi;
      if (word_zero || word_multi) err_d = sat_inc(err_q);
    end else if (release_w) begin
      // Result fields keep their last value once drained.
      state_d = EMPTY;
    end
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      a_q     <= '0;
      zero_q  <= 1'b0;
      multi_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      zero_q  <= zero_d;
      multi_q <= multi_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_a     = a_q;
  assign out_zero  = zero_q;
  assign out_multi = multi_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_encoder_4x2_reg.sv
module tb_encoder_4x2_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_y;
  logic       out_ready;

  logic       in_ready, in_ready_s;
  logic       out_valid, out_valid_s;
  logic [1:0] out_a, out_a_s;
  logic       out_zero, out_zero_s;
  logic       out_multi, out_multi_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;

  always #5 clk = ~clk;

  encoder_4x2_reg #(.N(4), .W(2), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_zero(out_zero), .out_multi(out_multi), .err_cnt(err_cnt)
  );

  // Narrow counter instance sharing the same stimulus, to exercise saturation.
  encoder_4x2_reg #(.N(4), .W(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_y(in_y), .out_valid(out_valid_s), .out_ready(out_ready), .out_a(out_a_s),
    .out_zero(out_zero_s), .out_multi(out_multi_s), .err_cnt(err_cnt_s)
  );

  typedef struct {
    int a;
    bit zero;
    bit multi;
    int e8;
    int e2;
  } exp_t;

  exp_t q[$];
  exp_t last_e;
  exp_t pend_e;

  int  checks = 0;
  int  errors = 0;
  bit  full_m = 0;
  bit  acc_pend = 0;
  int  err8_m = 0;
  int  err2_m = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: highest set bit found by scanning down from the MSB.
  function automatic exp_t model(input logic [3:0] y);
    exp_t e;
    e.a = 0;
    for (int i = 3; i >= 0; i--) begin
      if (y[i]) begin
        e.a = i;
        break;
      end
    end
    e.zero  = (y == 4'b0000);
    e.multi = ($countones(y) > 1);
    if (e.zero || e.multi) begin
      err8_m = (err8_m < 255) ? err8_m + 1 : 255;
      err2_m = (err2_m < 3) ? err2_m + 1 : 3;
    end
    e.e8 = err8_m;
    e.e2 = err2_m;
    return e;
  endfunction

  // One clock cycle of stimulus; the edge that opens the cycle commits the
  // previous cycle's accept/release into the scoreboard.
  task automatic step(input logic v, input logic [3:0] y, input logic r);
    @(posedge clk);
    if (acc_pend) begin
      q.push_back(pend_e);
      full_m = 1;
    end else if (full_m && out_ready) begin
      full_m = 0;
    end
    #1;
    in_valid  = v;
    in_y      = y;
    out_ready = r;
    acc_pend  = v && (!full_m || r);
    if (acc_pend) pend_e = model(y);
  endtask

  task automatic clear_model();
    q.delete();
    full_m   = 0;
    acc_pend = 0;
    err8_m   = 0;
    err2_m   = 0;
    last_e   = '{a: 0, zero: 0, multi: 0, e8: 0, e2: 0};
  endtask

  // Monitor: mid-cycle, compare presented outputs with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", int'(in_ready), int'((q.size() == 0) || out_ready));
      chk("in_ready_sat", int'(in_ready_s), int'((q.size() == 0) || out_ready));
      chk("out_valid", int'(out_valid), int'(q.size() != 0));
      chk("out_valid_sat", int'(out_valid_s), int'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_a", int'(out_a), q[0].a);
        chk("out_zero", int'(out_zero), int'(q[0].zero));
        chk("out_multi", int'(out_multi), int'(q[0].multi));
        chk("err_cnt", int'(err_cnt), q[0].e8);
        chk("err_cnt_sat", int'(err_cnt_s), q[0].e2);
        chk("out_a_sat", int'(out_a_s), q[0].a);
        if (out_ready) last_e = q.pop_front();
      end else begin
        chk("hold_out_a", int'(out_a), last_e.a);
        chk("hold_out_zero", int'(out_zero), int'(last_e.zero));
        chk("hold_out_multi", int'(out_multi), int'(last_e.multi));
        chk("hold_err_cnt", int'(err_cnt), last_e.e8);
        chk("hold_err_cnt_sat", int'(err_cnt_s), last_e.e2);
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_a", int'(out_a), 0);
    chk("rst_flags", int'({out_zero, out_multi}), 0);
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_y      = 4'b0000;
    out_ready = 1'b0;
    clear_model();
    #2;
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_in_ready", int'(in_ready), 1);
    chk("init_err_cnt", int'(err_cnt), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // One-hot sweep, back to back.
    step(1, 4'b0001, 1);
    step(1, 4'b0010, 1);
    step(1, 4'b0100, 1);
    step(1, 4'b1000, 1);
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);

    // Malformed words.
    step(1, 4'b0000, 1);
    step(1, 4'b0110, 1);
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);
    chk("malformed_err_cnt", int'(err_cnt), 2);

    // Backpressure: held result, blocked input, then swap on release.
    step(1, 4'b0100, 1);
    step(1, 4'b1000, 0);
    step(1, 4'b1000, 0);
    step(1, 4'b1000, 0);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_out_a_held", int'(out_a), 2);
    step(1, 4'b1000, 1);
    step(0, 4'b0000, 1);
    chk("bp_out_a_next", int'(out_a), 3);
    step(0, 4'b0000, 1);

    // Reset with a result held.
    step(1, 4'b0010, 0);
    step(1, 4'b0001, 0);
    #1;
    chk("pre_rst_out_valid", int'(out_valid), 1);
    do_reset();

    // Saturation on the narrow counter: expect 1,2,3,3,3.
    for (int k = 0; k < 5; k++) begin
      step(1, 4'b0000, 1);
    end
    step(0, 4'b0000, 1);
    step(0, 4'b0000, 1);
    chk("sat_err_cnt", int'(err_cnt_s), 3);
    chk("wide_err_cnt", int'(err_cnt), 5);

    // Randomised traffic, biased towards one-hot words.
    for (int k = 0; k < 1000; k++) begin
      logic [3:0] y;
      if ($urandom_range(0, 2) != 0) y = 4'b0001 << $urandom_range(0, 3);
      else y = 4'($urandom_range(0, 15));
      step($urandom_range(0, 3) != 0, y, $urandom_range(0, 3) != 0);
    end

    // Drain and confirm every accepted word was presented.
    for (int k = 0; k < 4; k++) begin
      step(0, 4'b0000, 1);
    end
    chk("drain_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
